// File: rtl/culsans_sram_arbiter.sv
// rtl/culsans_sram_arbiter.sv - round-robin arbiter for the shared single-port main SRAM
//
// Purpose: shares one single-port SRAM between NumReq requesters using a
// req/gnt/rvalid handshake. Grant is combinational round-robin starting at the
// registered pointer; the one-cycle-latency response is routed back to the
// requester granted in the previous cycle.
//
// Optional feature macro: CULSANS_SRAM_ARB_LOCK_EN
//   Defined   - bus lock: a granted transfer with lock_i set keeps exclusive
//               access for its requester until it issues a transfer with lock_i
//               clear, bounded by a MaxLockCycles watchdog (lock_err_o pulse).
//   Undefined - lock_i is ignored and lock_err_o is tied low.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_i/we_i/lock_i      per-requester request, write enable, lock request
//   addr_i/be_i/wdata_i    per-requester word address, byte enables, write data
//   gnt_o/rvalid_o         per-requester grant and response valid (one-hot or zero)
//   rdata_o                read data broadcast (pass-through of sram_rdata_i)
//   lock_err_o             watchdog forced a lock release
//   sram_*                 SRAM request side; sram_rdata_i valid one cycle after sram_req_o

module culsans_sram_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned MaxLockCycles = 64,
  localparam int unsigned BeWidth      = DataWidth / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0]                   lock_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                lock_err_o,
  output logic                                sram_req_o,
  output logic                                sram_we_o,
  output logic [AddrWidth-1:0]                sram_addr_o,
  output logic [BeWidth-1:0]                  sram_be_o,
  output logic [DataWidth-1:0]                sram_wdata_o,
  input  logic [DataWidth-1:0]                sram_rdata_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdxW-1:0]   r_rr;
  logic [NumReq-1:0] r_rvalid;

  logic [NumReq-1:0] w_req_eff;   // requests eligible this cycle (lock-filtered)
  logic [NumReq-1:0] w_gnt;
  logic [IdxW-1:0]   w_gnt_idx;
  logic [IdxW-1:0]   w_rr_next;
  logic              w_any_gnt;

  // Round-robin search: first eligible requester at or after r_rr, wrapping.
  always_comb begin
    int unsigned w_idx;
    logic [IdxW-1:0] w_sel;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_any_gnt = 1'b0;
    w_idx     = 0;
    w_sel     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      w_idx = {{(32-IdxW){1'b0}}, r_rr} + k;
      if (w_idx >= NumReq) begin
        w_idx = w_idx - NumReq;
      end
      w_sel = w_idx[IdxW-1:0];
      if (!w_any_gnt && w_req_eff[w_sel]) begin
        w_any_gnt     = 1'b1;
        w_gnt[w_sel]  = 1'b1;
        w_gnt_idx     = w_sel;
      end
    end
  end

  assign w_rr_next = (w_gnt_idx == IdxW'(NumReq - 1)) ? '0 : w_gnt_idx + IdxW'(1);

  // Payload mux from the granted requester; all zero when idle.
  always_comb begin
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (w_gnt[i]) begin
        sram_we_o    = we_i[i];
        sram_addr_o  = addr_i[i];
        sram_be_o    = be_i[i];
        sram_wdata_o = wdata_i[i];
      end
    end
  end

  assign gnt_o      = w_gnt;
  assign sram_req_o = w_any_gnt;
  assign rvalid_o   = r_rvalid;
  assign rdata_o    = sram_rdata_i;

  // Response valid mirrors the grant one cycle later, reads and writes alike.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rvalid <= '0;
    end else begin
      r_rvalid <= w_gnt;
    end
  end

`ifdef CULSANS_SRAM_ARB_LOCK_EN
  localparam int unsigned CntW = $clog2(MaxLockCycles + 1);

  logic            r_locked;
  logic [IdxW-1:0] r_owner;
  logic [CntW-1:0] r_lock_cnt;
  logic            w_wd;

  // Watchdog cycle: nobody is granted, the lock drops at the end of it and
  // round-robin resumes from the pointer left by the locking grant.
  assign w_wd       = r_locked && (r_lock_cnt == CntW'(MaxLockCycles));
  assign lock_err_o = w_wd;

  always_comb begin
    w_req_eff = req_i;
    if (w_wd) begin
      w_req_eff = '0;
    end else if (r_locked) begin
      w_req_eff          = '0;
      w_req_eff[r_owner] = req_i[r_owner];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr       <= '0;
      r_locked   <= 1'b0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else if (w_any_gnt) begin
      r_lock_cnt <= '0;
      if (r_locked) begin
        // Only the owner can be granted here; the pointer holds until release.
        if (!lock_i[w_gnt_idx]) begin
          r_locked <= 1'b0;
          r_rr     <= w_rr_next;
        end
      end else begin
        r_rr <= w_rr_next;
        if (lock_i[w_gnt_idx]) begin
          r_locked <= 1'b1;
          r_owner  <= w_gnt_idx;
        end
      end
    end else if (r_locked) begin
      if (w_wd) begin
        r_locked   <= 1'b0;
        r_lock_cnt <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + CntW'(1);
      end
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^{lock_i, (MaxLockCycles != 0)};
  assign w_req_eff     = req_i;
  assign lock_err_o    = 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (w_any_gnt) begin
      r_rr <= w_rr_next;
    end
  end
`endif

endmodule
